// File: rtl/apb_master_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_mux_if
// Description : Request/response port plus shared APB bus of apb_master_mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_mux_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
) ();
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W-1:0]      req_wdata;
    logic                   rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [7:0]             err_cnt;
    logic [NSLV-1:0]        psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [NSLV*DATA_W-1:0] prdata;
    logic [NSLV-1:0]        pready;
    logic [NSLV-1:0]        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_mux.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_mux
// Description : APB master with valid/ready front end, address-decoded slave
//               select and an ACCESS wait-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_mux #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_master_mux_if.master bus
);
    localparam int c_SEL_W = $clog2(NSLV);
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_SEL_W-1:0]  r_sel;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic [NSLV-1:0]     r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [7:0]          r_err_cnt;

    logic                w_req_ready;
    logic [c_SEL_W-1:0]  w_sel_req;
    logic [NSLV-1:0]     w_sel_onehot;
    logic [DATA_W-1:0]   w_prdata [NSLV];
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_pready;
    logic                w_pslverr;
    logic                w_timeout;
    logic                w_xfer_err;

    assign w_req_ready  = presetn && (r_state == ST_IDLE);
    assign w_sel_req    = bus.req_addr[ADDR_W-1 -: c_SEL_W];
    assign w_sel_onehot = {{(NSLV-1){1'b0}}, 1'b1} << w_sel_req;

    for (genvar gi = 0; gi < NSLV; gi++) begin : g_prdata
        assign w_prdata[gi] = bus.prdata[gi*DATA_W +: DATA_W];
    end

    // Only the addressed slave is observed; the rest of the bus is don't-care.
    assign w_rdata_sel = w_prdata[r_sel];
    assign w_pready    = bus.pready[r_sel];
    assign w_pslverr   = bus.pslverr[r_sel];
    assign w_xfer_err  = w_pready ? w_pslverr : 1'b1;

    // Fires on the last permitted low-pready ACCESS cycle; pready still wins.
    if (TIMEOUT > 0) begin : g_timeout
        assign w_timeout = (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_wait_cnt  <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_paddr  <= bus.req_addr;
                        r_pwrite <= bus.req_write;
                        r_pwdata <= bus.req_wdata;
                        r_sel    <= w_sel_req;
                        r_psel   <= w_sel_onehot;
                        r_state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_pready || w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_xfer_err;
                        r_rsp_rdata <= (w_pready && !w_pslverr && !r_pwrite) ? w_rdata_sel : '0;
                        if (w_xfer_err && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_mux
// Description : Randomised and directed bench for apb_master_mux against a
//               transaction-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_apb_master_mux;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int T  = 4;

    logic pclk = 1'b0;
    logic presetn;
    always #5 pclk = ~pclk;

    apb_master_mux_if #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS)) bus ();

    apb_master_mux #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT(T)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            w;      // low-pready ACCESS cycles before the slave answers
        logic          perr;
        logic [DW-1:0] prd;
    } req_t;

    req_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // request source
    bit   presenting = 0;
    req_t cur;
    int   gap = 0;
    bit   hold_mode = 0;

    // reference model: current transfer occupies cycles k..k+n, response at k+n+1
    bit            busy = 0;
    int            k = 0;
    int            n = 0;
    req_t          x;
    logic [1:0]    x_sel;
    logic [DW-1:0] x_rdata;
    logic          x_err;

    logic          e_ready, e_pen, e_pwrite, e_rvalid, e_err;
    logic [NS-1:0] e_psel;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;
    int            e_ecnt;

    // observations of the DUT for the hand-computed checks
    int            acc_cyc = 0, rsp_cyc = 0, pen_cnt = 0;
    logic [NS-1:0] psel_seen = '0;
    logic [DW-1:0] got_rdata = '0;
    logic          got_err = 1'b0;
    int            acc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; presenting = 0; gap = 0;
        e_ready = 1'b1; e_psel = '0; e_pen = 1'b0; e_pwrite = 1'b0;
        e_paddr = '0; e_pwdata = '0; e_rvalid = 1'b0; e_rdata = '0; e_err = 1'b0;
        e_ecnt = 0;
    endtask

    task automatic drive_and_model();
        int  c = cyc;
        int  e = cyc + 1;
        bit  inx;
        if (!presenting) begin
            if (gap > 0) gap--;
            else if (q.size() > 0) begin
                cur = q.pop_front();
                presenting = 1;
            end
        end
        if (presenting) begin
            bus.req_valid = 1'b1;
            bus.req_write = cur.wr;
            bus.req_addr  = cur.addr;
            bus.req_wdata = cur.wdata;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = AW'($urandom);
            bus.req_wdata = $urandom;
        end
        for (int i = 0; i < NS; i++) begin
            bus.pready[i]  = 1'($urandom_range(0, 1));
            bus.pslverr[i] = 1'($urandom_range(0, 1));
            bus.prdata[i*DW +: DW] = $urandom;
        end
        if (busy && c >= k + 1 && c <= k + n) begin
            bus.pready[x_sel]  = ((c - (k + 1)) >= x.w);
            bus.pslverr[x_sel] = x.perr;
            bus.prdata[x_sel*DW +: DW] = x.prd;
        end
        if (bus.req_valid && bus.req_ready) begin
            acc_cyc = e; pen_cnt = 0; psel_seen = '0;
            acc_q.push_back(e);
        end
        if (presenting && !(busy && c >= k && c <= k + n)) begin
            busy = 1; k = e; x = cur; x_sel = cur.addr[AW-1 -: 2];
            if (cur.w < T) begin
                n = cur.w + 1; x_err = cur.perr;
                x_rdata = (!cur.wr && !cur.perr) ? cur.prd : '0;
            end else begin
                n = T; x_err = 1'b1; x_rdata = '0;
            end
            e_paddr = cur.addr; e_pwrite = cur.wr; e_pwdata = cur.wdata;
            presenting = 0;
            gap = hold_mode ? 0 : $urandom_range(0, 2);
        end
        inx      = busy && e >= k && e <= k + n;
        e_ready  = !inx;
        e_psel   = inx ? (NS'(1) << x_sel) : '0;
        e_pen    = inx && (e > k);
        e_rvalid = busy && (e == k + n + 1);
        if (e_rvalid) begin
            e_rdata = x_rdata; e_err = x_err;
            if (x_err && e_ecnt < 255) e_ecnt++;
        end
    endtask

    task automatic compare();
        chk("req_ready", bus.req_ready, e_ready);
        chk("psel",      bus.psel,      e_psel);
        chk("penable",   bus.penable,   e_pen);
        chk("pwrite",    bus.pwrite,    e_pwrite);
        chk("paddr",     bus.paddr,     e_paddr);
        chk("pwdata",    bus.pwdata,    e_pwdata);
        chk("rsp_valid", bus.rsp_valid, e_rvalid);
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("rsp_err",   bus.rsp_err,   e_err);
        chk("err_cnt",   bus.err_cnt,   e_ecnt);
        if (bus.penable) pen_cnt++;
        psel_seen = psel_seen | bus.psel;
        if (bus.rsp_valid) begin
            rsp_cyc = cyc; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
        end
    endtask

    task automatic step();
        @(negedge pclk);
        drive_and_model();
        @(posedge pclk);
        cyc++;
        #1;
        compare();
    endtask

    task automatic release_reset();
        @(negedge pclk);
        bus.req_valid = 1'b0;
        presetn = 1'b1;
        model_reset();
        @(posedge pclk);
        cyc++;
        #1;
        compare();
    endtask

    task automatic drain(input int bound, input string name);
        int t = 0;
        while ((q.size() > 0 || presenting || (busy && cyc <= k + n + 1)) && t < bound) begin
            step();
            t++;
        end
        chk({name, "_drain"}, 64'(t >= bound), 64'd0);
    endtask

    task automatic one(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int w, input logic perr, input logic [DW-1:0] prd);
        req_t r;
        r.wr = wr; r.addr = addr; r.wdata = wdata; r.w = w; r.perr = perr; r.prd = prd;
        q.push_back(r);
        drain(60, "xfer");
    endtask

    function automatic req_t rand_req(input int wmax, input logic perr);
        req_t r;
        r.wr = 1'($urandom_range(0, 1)); r.addr = AW'($urandom); r.wdata = $urandom;
        r.w = $urandom_range(0, wmax); r.perr = perr; r.prd = $urandom;
        return r;
    endfunction

    initial begin
        int t;
        presetn = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.prdata = '0; bus.pready = '0; bus.pslverr = '0;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_psel", bus.psel, 0);       chk("rst_penable", bus.penable, 0);
        chk("rst_ready", bus.req_ready, 0); chk("rst_rvalid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.paddr, 0);     chk("rst_errcnt", bus.err_cnt, 0);
        release_reset();
        repeat (2) step();

        one(1'b1, 16'h4010, 32'hDEADBEEF, 0, 1'b0, '0);
        chk("zw_psel", psel_seen, 4'b0010); chk("zw_pen_cycles", pen_cnt, 1);
        chk("zw_latency", rsp_cyc - acc_cyc, 2); chk("zw_err", got_err, 0);
        chk("zw_pwdata", bus.pwdata, 32'hDEADBEEF);

        one(1'b0, 16'hC004, $urandom, 3, 1'b0, 32'h12345678);
        chk("rd3_psel", psel_seen, 4'b1000); chk("rd3_pen_cycles", pen_cnt, 4);
        chk("rd3_latency", rsp_cyc - acc_cyc, 5); chk("rd3_rdata", got_rdata, 32'h12345678);

        one(1'b0, 16'h8000 | AW'($urandom_range(0, 16'h3FFF)), $urandom, 0, 1'b1, $urandom);
        chk("serr_err", got_err, 1); chk("serr_rdata", got_rdata, 0);
        chk("serr_errcnt", bus.err_cnt, 1);

        one(1'b0, 16'h0010, $urandom, 99, 1'b0, $urandom);
        chk("to_psel", psel_seen, 4'b0001); chk("to_pen_cycles", pen_cnt, 4);
        chk("to_latency", rsp_cyc - acc_cyc, 5); chk("to_err", got_err, 1);
        chk("to_rdata", got_rdata, 0); chk("to_errcnt", bus.err_cnt, 2);

        one(1'b0, 16'h0020, $urandom, 3, 1'b0, 32'hCAFEF00D);
        chk("to4_pen_cycles", pen_cnt, 4); chk("to4_err", got_err, 0);
        chk("to4_rdata", got_rdata, 32'hCAFEF00D);

        // reset while a write sits in ACCESS
        q.push_back(rand_req(0, 1'b0));
        q[0].wr = 1'b1; q[0].w = 10;
        t = 0;
        while (!(busy && cyc >= k + 1) && t < 20) begin step(); t++; end
        chk("mrst_reach", 64'(t >= 20), 0);
        #2 presetn = 1'b0;
        #1;
        chk("mrst_psel", bus.psel, 0); chk("mrst_penable", bus.penable, 0);
        chk("mrst_ready", bus.req_ready, 0);
        repeat (3) begin
            @(posedge pclk); #1;
            chk("mrst_rvalid", bus.rsp_valid, 0);
        end
        release_reset();
        chk("mrst_ready_after", bus.req_ready, 1); chk("mrst_errcnt", bus.err_cnt, 0);
        repeat (6) step();

        // back-to-back with req_valid held high
        hold_mode = 1; gap = 0;
        acc_q.delete();
        repeat (5) q.push_back(rand_req(0, 1'b0));
        drain(60, "b2b");
        chk("b2b_accepts", acc_q.size(), 5);
        for (int i = 1; i < 5; i++) chk("b2b_spacing", acc_q[i] - acc_q[i-1], 3);
        hold_mode = 0;

        repeat (300) q.push_back(rand_req(6, 1'($urandom_range(0, 3) == 0)));
        drain(5000, "rand");

        hold_mode = 1;
        repeat (260) q.push_back(rand_req(0, 1'b1));
        drain(2000, "sat");
        chk("sat_errcnt", bus.err_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/apb_master_mux.md
# apb_master_mux

Parametrised APB master with a request/response front end, address-decoded multi-slave select, and a wait-state timeout. It replaces the fixed two-slave, 8-bit master. Upstream logic issues one transfer at a time over a valid/ready request port. The block drives a shared APB bus (PADDR/PWRITE/PWDATA/PENABLE) plus one PSEL per slave, then returns read data and error status on a one-cycle response strobe.

## Interface
- ADDR_W, 16, address width; slave index is the top log2(NSLV) bits of the address.
- DATA_W, 32, read/write data width.
- NSLV, 4, number of slaves; power of two, 2..16.
- TIMEOUT, 15, ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- presetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transfer address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR or timeout on this transfer.
- err_cnt  out  8  saturating count of error responses.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NSLV*DATA_W  slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- **IDLE**
  - req_ready = 1, except forced to 0 while presetn is low.
  - When req_valid && req_ready at a rising edge: register addr, write, and wdata onto paddr/pwrite/pwdata, and compute sel = req_addr[ADDR_W-1 -: log2(NSLV)].
  - Next state: SETUP.
- **SETUP**
  - psel[sel] = 1, penable = 0, req_ready = 0.
  - Unconditional transition to ACCESS.
- **ACCESS**
  - psel[sel] = 1, penable = 1. The wait counter is cleared on entry.
  - Only the selected slave's pready/pslverr/prdata are observed; all other slaves' inputs are ignored.
- **Completion:** pready[sel] = 1 in ACCESS.
  - rsp_valid = 1 next cycle.
  - rsp_err = pslverr[sel].
  - rsp_rdata = prdata[sel] if read and no error, else 0.
  - psel and penable drop to 0. Next state: IDLE.
- **Timeout:** TIMEOUT > 0 and the TIMEOUT-th consecutive ACCESS cycle ends with pready[sel] = 0.
  - Response with rsp_err = 1, rsp_rdata = 0. Next state: IDLE.
  - If pready rises in the same cycle the timeout would fire, normal completion wins.
- **err_cnt:** increments on every rsp_valid with rsp_err = 1; saturates at 255.
- **Bus hold:** paddr, pwrite, and pwdata hold their value from SETUP through ACCESS. In IDLE they keep their last value. They change only on request acceptance.
- **Outputs:** all outputs are registered except req_ready, which is decoded from state.

## Timing
- **Reset values:** psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_cnt = 0. State is IDLE and the wait counter is 0.
- **Zero-wait transfer**
  - Acceptance at edge E0.
  - SETUP during cycle E0–E1; ACCESS during E1–E2.
  - Completion sampled at E2; rsp_valid high during E2–E3.
  - Next acceptance is possible at E3, giving 3 cycles per transfer minimum.
- **Wait states:** each cycle pready[sel] is low adds one ACCESS cycle. With TIMEOUT = T, the worst-case abort is sampled at edge E1+T.
- rsp_valid is high for exactly one cycle and has no backpressure; upstream must capture it. rsp_rdata and rsp_err hold until the next response.
- **Request port:** req_valid while req_ready = 0 is ignored; upstream must hold the request until it is accepted.
- **Reset mid-transfer:** presetn low at any point forces the reset values immediately (asynchronously). The transfer is dropped with no response, and the FSM restarts in IDLE after presetn deasserts.

## Test plan
- **Reset:** assert presetn = 0 during ACCESS of a write. Required: psel = 0 and penable = 0 immediately, rsp_valid never pulses, and after release req_ready = 1 with err_cnt = 0.
- **Zero-wait write:** req_addr = 0x4010, req_wdata = 0xDEADBEEF, slave 1 pready = 1, with the defaults. Required: psel = 4'b0010, penable high for exactly 1 cycle, pwdata stable across SETUP/ACCESS, rsp_valid 2 cycles after accept, rsp_err = 0.
- **Read with 3 wait states:** req_addr = 0xC004; slave 3 returns prdata = 0x12345678 after 3 low-pready cycles. Required: ACCESS lasts 4 cycles, rsp_rdata = 0x12345678, other slaves' prdata are ignored.
- **Slave error:** read from slave 2 with pslverr = 1 on the pready cycle. Required: rsp_err = 1, rsp_rdata = 0, err_cnt increments by 1.
- **Timeout:** TIMEOUT = 4, slave 0 pready held low. Required: abort after exactly 4 ACCESS cycles with rsp_err = 1. A second run with pready rising on the 4th cycle must complete with rsp_err = 0.
- **Back-to-back:** req_valid held high for 5 transfers. Required: one accept every 3 cycles, no accept outside IDLE, and 256 error responses leave err_cnt = 255.
